branch_predict_resolve: RTL and testbench

Execute-stage branch resolver with a fetch-stage branch target buffer (BTB) and saturating-counter direction predictor. It generalises the combinational branch-condition logic:
- resolves beq/bne/blt/bge/bltu/bgeu/jal/jalr from the same PCS/Funct3/ALUFlags encoding;
- predicts at fetch, detects mispredictions in execute and trains its table;
- keeps saturating performance counters.

It sits between the fetch PC mux and the EX stage and drives the pipeline's flush/redirect.

---
 rtl/branch_predict_resolve.sv | 154 +++++++++++++++
 tb/tb_branch_predict_resolve.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: fetch-side BTB with saturating direction counters,
// EX-side branch resolution, mispredict/redirect generation and perf counters.
module branch_predict_resolve #(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [PC_WIDTH-1:0]   PCF,
    output logic                  PredTakenF,
    output logic [PC_WIDTH-1:0]   PredTargetF,
    input  logic                  ValidE,
    input  logic                  StallE,
    input  logic [1:0]            PCSE,
    input  logic [2:0]            Funct3E,
    input  logic [2:0]            ALUFlagsE,
    input  logic [PC_WIDTH-1:0]   PCE,
    input  logic [PC_WIDTH-1:0]   BranchTargetE,
    input  logic                  PredTakenE,
    input  logic [PC_WIDTH-1:0]   PredTargetE,
    output logic                  TakenE,
    output logic                  MispredictE,
    output logic [PC_WIDTH-1:0]   RedirectPCE,
    output logic [STAT_WIDTH-1:0] BranchCount,
    output logic [STAT_WIDTH-1:0] MispredictCount
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [1:0] PCS_NONE = 2'b00;
    localparam logic [1:0] PCS_COND = 2'b01;
    localparam logic [1:0] PCS_JAL  = 2'b10;
    localparam logic [1:0] PCS_JALR = 2'b11;

    // weakly taken = MSB set, rest clear; weakly not taken is its complement
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = ~CTR_WT;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // BTB storage; kind holds the PCS code that allocated the entry
    logic                vld_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q  [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q  [ENTRIES];
    logic [1:0]          kind_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q  [ENTRIES];

    logic [IDX-1:0]   idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic             cond_taken;
    logic             upd_en;

    // PC bits [1:0] never take part in indexing or tagging
    logic unused_ok;
    assign unused_ok = &{1'b0, PCF[1:0], PCE[1:0]};

    // fetch read port: reads registered state only, so same-cycle writes are not seen
    assign idx_f       = PCF[IDX+1:2];
    assign tag_f       = PCF[PC_WIDTH-1:IDX+2];
    assign hit_f       = vld_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && ((kind_q[idx_f] != PCS_COND) || ctr_q[idx_f][CTR_BITS-1]);
    assign PredTargetF = hit_f ? tgt_q[idx_f] : '0;

    // EX read port used to decide between training and allocation
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[PC_WIDTH-1:IDX+2];
    assign hit_e = vld_q[idx_e] && (tag_q[idx_e] == tag_e);

    // branch condition from Funct3 and {eq, lt, ltu}, then select by PCS kind
    always_comb begin
        cond_taken = 1'b0;
        TakenE     = 1'b0;
        case (Funct3E)
            3'b000:  cond_taken =  ALUFlagsE[2];
            3'b001:  cond_taken = ~ALUFlagsE[2];
            3'b100:  cond_taken =  ALUFlagsE[1];
            3'b101:  cond_taken = ~ALUFlagsE[1];
            3'b110:  cond_taken =  ALUFlagsE[0];
            3'b111:  cond_taken = ~ALUFlagsE[0];
            default: cond_taken = 1'b0;
        endcase
        case (PCSE)
            PCS_COND:          TakenE = cond_taken;
            PCS_JAL, PCS_JALR: TakenE = 1'b1;
            default:           TakenE = 1'b0;
        endcase
    end

    // reset term keeps the flush quiet while the table is being cleared
    assign upd_en      = ValidE && !StallE;
    assign MispredictE = RESETn && upd_en &&
                         ((TakenE != PredTakenE) || (TakenE && (BranchTargetE != PredTargetE)));
    assign RedirectPCE = TakenE ? BranchTargetE : PCE + PC_WIDTH'(4);

    // table training / allocation / alias invalidation on a real, unstalled EX op
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i]  <= 1'b0;
                tag_q[i]  <= '0;
                tgt_q[i]  <= '0;
                kind_q[i] <= PCS_NONE;
                ctr_q[i]  <= CTR_WNT;
            end
        end else if (upd_en) begin
            case (PCSE)
                PCS_COND: begin
                    if (hit_e) begin
                        if (TakenE) begin
                            if (ctr_q[idx_e] != CTR_MAX) ctr_q[idx_e] <= ctr_q[idx_e] + 1'b1;
                            tgt_q[idx_e] <= BranchTargetE;
                        end else if (ctr_q[idx_e] != '0) begin
                            ctr_q[idx_e] <= ctr_q[idx_e] - 1'b1;
                        end
                    end else if (TakenE) begin
                        vld_q[idx_e]  <= 1'b1;
                        tag_q[idx_e]  <= tag_e;
                        tgt_q[idx_e]  <= BranchTargetE;
                        kind_q[idx_e] <= PCS_COND;
                        ctr_q[idx_e]  <= CTR_WT;
                    end
                end
                PCS_JAL, PCS_JALR: begin
                    vld_q[idx_e]  <= 1'b1;
                    tag_q[idx_e]  <= tag_e;
                    tgt_q[idx_e]  <= BranchTargetE;
                    kind_q[idx_e] <= PCSE;
                    if (!hit_e) ctr_q[idx_e] <= CTR_MAX;
                end
                default: begin
                    if (hit_e) vld_q[idx_e] <= 1'b0;
                end
            endcase
        end
    end

    // saturating performance counters
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else if (upd_en) begin
            if ((PCSE != PCS_NONE) && (BranchCount != STAT_MAX))
                BranchCount <= BranchCount + 1'b1;
            if (MispredictE && (MispredictCount != STAT_MAX))
                MispredictCount <= MispredictCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: two geometries (16-entry/32-bit stats and
// 4-entry/4-bit stats) share one stimulus stream and one behavioural model.
module tb_branch_predict_resolve;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [31:0] PCF, PCE, BranchTargetE, PredTargetE;
    logic        ValidE, StallE, PredTakenE;
    logic [1:0]  PCSE;
    logic [2:0]  Funct3E, ALUFlagsE;

    logic        pt_f0, tk0, mp0, pt_f1, tk1, mp1;
    logic [31:0] tg_f0, rd0, bc0, mc0, tg_f1, rd1;
    logic [3:0]  bc1, mc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    branch_predict_resolve #(.PC_WIDTH(32), .ENTRIES(16), .CTR_BITS(2), .STAT_WIDTH(32)) dut0 (
        .CLK(CLK), .RESETn(RESETn), .PCF(PCF), .PredTakenF(pt_f0), .PredTargetF(tg_f0),
        .ValidE(ValidE), .StallE(StallE), .PCSE(PCSE), .Funct3E(Funct3E), .ALUFlagsE(ALUFlagsE),
        .PCE(PCE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .TakenE(tk0), .MispredictE(mp0), .RedirectPCE(rd0), .BranchCount(bc0), .MispredictCount(mc0));

    branch_predict_resolve #(.PC_WIDTH(32), .ENTRIES(4), .CTR_BITS(2), .STAT_WIDTH(4)) dut1 (
        .CLK(CLK), .RESETn(RESETn), .PCF(PCF), .PredTakenF(pt_f1), .PredTargetF(tg_f1),
        .ValidE(ValidE), .StallE(StallE), .PCSE(PCSE), .Funct3E(Funct3E), .ALUFlagsE(ALUFlagsE),
        .PCE(PCE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .TakenE(tk1), .MispredictE(mp1), .RedirectPCE(rd1), .BranchCount(bc1), .MispredictCount(mc1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        v;
        bit [31:0] tag;
        bit [31:0] tgt;
        int        kind;   // 1 cond, 2 jal, 3 jalr
        int        ctr;    // 0..3
    } ent_t;

    ent_t   mdl [2][16];
    int     n_ent [2];
    int     lg    [2];
    longint smax  [2];
    longint m_bc  [2];
    longint m_mc  [2];

    function automatic int m_idx(int w, bit [31:0] pc);
        return int'((pc >> 2) % n_ent[w]);
    endfunction

    function automatic bit [31:0] m_tag(int w, bit [31:0] pc);
        return pc >> (2 + lg[w]);
    endfunction

    function automatic bit m_hit(int w, bit [31:0] pc);
        int i = m_idx(w, pc);
        return mdl[w][i].v && (mdl[w][i].tag == m_tag(w, pc));
    endfunction

    function automatic bit m_pt(int w, bit [31:0] pc);
        int i = m_idx(w, pc);
        return m_hit(w, pc) && (mdl[w][i].kind != 1 || mdl[w][i].ctr >= 2);
    endfunction

    function automatic bit [31:0] m_tg(int w, bit [31:0] pc);
        return m_hit(w, pc) ? mdl[w][m_idx(w, pc)].tgt : 32'h0;
    endfunction

    function automatic bit m_taken();
        bit eq  = ALUFlagsE[2];
        bit lt  = ALUFlagsE[1];
        bit ltu = ALUFlagsE[0];
        if (PCSE == 2'd0) return 1'b0;
        if (PCSE != 2'd1) return 1'b1;
        case (Funct3E)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_mp();
        bit tk = m_taken();
        return ValidE && !StallE && (tk != PredTakenE || (tk && BranchTargetE != PredTargetE));
    endfunction

    task automatic m_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                mdl[w][i].v    = 1'b0;
                mdl[w][i].tag  = 32'h0;
                mdl[w][i].tgt  = 32'h0;
                mdl[w][i].kind = 0;
                mdl[w][i].ctr  = 1;
            end
            m_bc[w] = 0;
            m_mc[w] = 0;
        end
    endtask

    task automatic m_update();
        bit tk = m_taken();
        bit mp = m_mp();
        if (!(ValidE && !StallE)) return;
        for (int w = 0; w < 2; w++) begin
            int i = m_idx(w, PCE);
            bit h = m_hit(w, PCE);
            if (PCSE != 2'd0 && m_bc[w] < smax[w]) m_bc[w]++;
            if (mp && m_mc[w] < smax[w]) m_mc[w]++;
            if (PCSE == 2'd1) begin
                if (h) begin
                    if (tk) begin
                        if (mdl[w][i].ctr < 3) mdl[w][i].ctr++;
                        mdl[w][i].tgt = BranchTargetE;
                    end else if (mdl[w][i].ctr > 0) begin
                        mdl[w][i].ctr--;
                    end
                end else if (tk) begin
                    mdl[w][i].v    = 1'b1;
                    mdl[w][i].tag  = m_tag(w, PCE);
                    mdl[w][i].tgt  = BranchTargetE;
                    mdl[w][i].kind = 1;
                    mdl[w][i].ctr  = 2;
                end
            end else if (PCSE != 2'd0) begin
                if (!h) mdl[w][i].ctr = 3;
                mdl[w][i].v    = 1'b1;
                mdl[w][i].tag  = m_tag(w, PCE);
                mdl[w][i].tgt  = BranchTargetE;
                mdl[w][i].kind = int'(PCSE);
            end else if (h) begin
                mdl[w][i].v = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        bit        tk = m_taken();
        bit [31:0] rd = tk ? BranchTargetE : PCE + 32'd4;
        chk("pred_taken0",  pt_f0, m_pt(0, PCF));
        chk("pred_target0", tg_f0, m_tg(0, PCF));
        chk("pred_taken1",  pt_f1, m_pt(1, PCF));
        chk("pred_target1", tg_f1, m_tg(1, PCF));
        chk("taken0",       tk0, tk);
        chk("taken1",       tk1, tk);
        chk("mispred0",     mp0, m_mp());
        chk("mispred1",     mp1, m_mp());
        chk("redirect0",    rd0, rd);
        chk("redirect1",    rd1, rd);
        chk("brcount0",     bc0, m_bc[0]);
        chk("mpcount0",     mc0, m_mc[0]);
        chk("brcount1",     bc1, m_bc[1]);
        chk("mpcount1",     mc1, m_mc[1]);
    endtask

    // drive one EX/fetch cycle, compare, then advance the model past the edge
    task automatic step(input bit v, input bit st, input bit [1:0] pcs, input bit [2:0] f3,
                        input bit [2:0] fl, input bit [31:0] pcf, input bit [31:0] pce,
                        input bit [31:0] bt, input bit pte, input bit [31:0] ptge);
        @(negedge CLK);
        ValidE = v; StallE = st; PCSE = pcs; Funct3E = f3; ALUFlagsE = fl;
        PCF = pcf; PCE = pce; BranchTargetE = bt; PredTakenE = pte; PredTargetE = ptge;
        #2;
        check_all();
        m_update();
    endtask

    task automatic bubble(input bit [31:0] pcf);
        step(1'b0, 1'b0, 2'b00, 3'b000, 3'b000, pcf, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    bit [31:0] pool [8];

    initial begin
        n_ent = '{16, 4};
        lg    = '{4, 2};
        smax  = '{64'hFFFF_FFFF, 64'd15};
        pool  = '{32'h100, 32'h104, 32'h110, 32'h200, 32'h240, 32'h300, 32'h1100, 32'h2104};

        // reset with a would-be mispredict on the EX inputs
        RESETn = 1'b0; ValidE = 1'b1; StallE = 1'b0; PCSE = 2'b10; Funct3E = 3'b000;
        ALUFlagsE = 3'b000; PCF = 32'h100; PCE = 32'h100; BranchTargetE = 32'h180;
        PredTakenE = 1'b0; PredTargetE = 32'h0;
        m_reset();
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_pred_taken",  pt_f0, 1'b0);
        chk("rst_pred_target", tg_f0, 32'h0);
        chk("rst_mispred",     mp0, 1'b0);
        chk("rst_brcount",     bc0, 32'h0);
        chk("rst_mpcount",     mc0, 32'h0);
        RESETn = 1'b1;

        // reset pulse while a jal allocation is on the inputs: nothing written
        @(negedge CLK);
        ValidE = 1'b1; StallE = 1'b0; PCSE = 2'b10; PCE = 32'h400; PCF = 32'h400;
        BranchTargetE = 32'h500; PredTakenE = 1'b0; PredTargetE = 32'h0;
        #2 RESETn = 1'b0;
        #1 chk("midrst_mispred", mp0, 1'b0);
        @(posedge CLK);
        #2 RESETn = 1'b1;
        m_reset();
        bubble(32'h400);
        chk("midrst_no_entry", pt_f0, 1'b0);

        // beq taken, first sighting
        step(1, 0, 2'b01, 3'b000, 3'b100, 32'h0, 32'h100, 32'h180, 1'b0, 32'h0);
        chk("beq_mispred",  mp0, 1'b1);
        chk("beq_redirect", rd0, 32'h180);
        bubble(32'h100);
        chk("beq_pred_taken",  pt_f0, 1'b1);
        chk("beq_pred_target", tg_f0, 32'h180);
        chk("beq_mpcount",     mc0, 32'd1);

        // resolved not taken twice from weakly taken
        step(1, 0, 2'b01, 3'b000, 3'b000, 32'h0, 32'h100, 32'h180, 1'b1, 32'h180);
        chk("bnt1_mispred",  mp0, 1'b1);
        chk("bnt1_redirect", rd0, 32'h104);
        step(1, 0, 2'b01, 3'b000, 3'b000, 32'h0, 32'h100, 32'h180, 1'b0, 32'h0);
        chk("bnt2_mispred",  mp0, 1'b0);
        bubble(32'h100);
        chk("bnt_pred_taken", pt_f0, 1'b0);

        // jalr target change
        step(1, 0, 2'b11, 3'b000, 3'b000, 32'h0, 32'h200, 32'h300, 1'b0, 32'h0);
        step(1, 0, 2'b11, 3'b000, 3'b000, 32'h0, 32'h200, 32'h340, 1'b1, 32'h300);
        chk("jalr_mispred",  mp0, 1'b1);
        chk("jalr_redirect", rd0, 32'h340);
        bubble(32'h200);
        chk("jalr_new_target", tg_f0, 32'h340);

        // non-control op hits a stale entry: flush and invalidate
        step(1, 0, 2'b00, 3'b000, 3'b000, 32'h0, 32'h100, 32'h0, 1'b1, 32'h180);
        chk("alias_mispred",  mp0, 1'b1);
        chk("alias_redirect", rd0, 32'h104);
        bubble(32'h100);
        chk("alias_invalid", tg_f0, 32'h0);

        // stalled for three cycles, then released
        repeat (3) begin
            step(1, 1, 2'b01, 3'b001, 3'b000, 32'h0, 32'h240, 32'h280, 1'b0, 32'h0);
            chk("stall_mispred", mp0, 1'b0);
        end
        step(1, 0, 2'b01, 3'b001, 3'b000, 32'h0, 32'h240, 32'h280, 1'b0, 32'h0);
        chk("release_mispred", mp0, 1'b1);

        // 0x100 and 0x110 share index 0 only in the 4-entry table
        step(1, 0, 2'b01, 3'b000, 3'b100, 32'h0, 32'h100, 32'h180, 1'b0, 32'h0);
        step(1, 0, 2'b10, 3'b000, 3'b000, 32'h0, 32'h110, 32'h500, 1'b0, 32'h0);
        bubble(32'h100);
        chk("evict_small", tg_f1, 32'h0);
        chk("keep_large",  tg_f0, 32'h180);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit [31:0] pce  = pool[$urandom_range(0, 7)];
            bit [31:0] bt   = pool[$urandom_range(0, 7)] + 32'h400;
            bit        pte;
            bit [31:0] ptge;
            if ($urandom_range(0, 1) == 1) begin
                pte  = m_pt(0, pce);
                ptge = m_tg(0, pce);
            end else begin
                pte  = 1'($urandom_range(0, 1));
                ptge = ($urandom_range(0, 1) == 1) ? bt : pool[$urandom_range(0, 7)];
            end
            step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 pool[$urandom_range(0, 7)], pce, bt, pte, ptge);
        end

        // 4-bit branch counter has long since saturated
        bubble(32'h0);
        chk("stat_saturated", bc1, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
